mont_reduce_arbiter: RTL and testbench
======================================

Name: mont_reduce_arbiter

Overview:
Shares one pipelined Montgomery reduction unit between two requesters, typically two NTT butterfly lanes. Each requester issues 32-bit products over valid/ready and gets back 16-bit reduced coefficients in issue order. The block arbitrates round-robin, drives the shared unit and tracks in-flight owner tags through the unit's fixed latency. A credit scheme and per-requester response FIFOs absorb response backpressure without stalling the shared unit.

Parameters:
MR_LAT, 2, cycles from mr_a presented to matching mr_result valid (>=1)
FDEPTH, 4, per-requester response FIFO depth and credit limit (power of 2, >=2)
DWID, 32, product width
RWID, 16, reduced result width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 product valid
req0_ready  out  1  requester 0 accept
req0_a  in  DWID  requester 0 product
req1_valid  in  1  requester 1 product valid
req1_ready  out  1  requester 1 accept
req1_a  in  DWID  requester 1 product
rsp0_valid  out  1  requester 0 result valid
rsp0_ready  in  1  requester 0 result accept
rsp0_data  out  RWID  requester 0 result
rsp1_valid  out  1  requester 1 result valid
rsp1_ready  in  1  requester 1 result accept
rsp1_data  out  RWID  requester 1 result
mr_valid  out  1  issue strobe to the shared unit (debug/power gating)
mr_a  out  DWID  operand to the shared unit (registered)
mr_result  in  RWID  result from the shared unit, no valid of its own

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- Reset values: req*_ready=0, rsp*_valid=0, rsp*_data=0, mr_valid=0, mr_a=0, prio=0. Tag pipeline, FIFOs and credit counters are cleared.
- Credits: credit_i counts in-flight ops plus FIFO occupancy for requester i, range 0..FDEPTH.
  - eligible_i = req_i_valid && credit_i < FDEPTH.
  - credit_i increments on accept and decrements on the rsp_i pop. Both in the same cycle leave it unchanged.
- Arbitration is combinational within the cycle:
  - Both eligible: grant the one indicated by prio.
  - Only one eligible: grant it.
  - Neither eligible: no grant.
  - req_i_ready = grant_i, so at most one ready per cycle. Ready may depend on valid.
  - After any grant, prio points at the other requester. With no grant, prio holds.
- Issue: on accept in cycle C, register mr_a <= req_a and mr_valid <= 1. Cycle C+1 presents the operand. With no accept, mr_valid <= 0 and mr_a holds.
- Tag pipeline: MR_LAT-stage shift of {valid, owner}, entered at the issue register. The stage aligned with cycle C+1+MR_LAT qualifies mr_result, which is written into owner's FIFO at the end of that cycle.
- Latency: rsp_valid asserts in cycle C+2+MR_LAT at the earliest (C+4 at the default).
- One issue per cycle gives full throughput: back-to-back accepts produce back-to-back results.
- FIFOs: FIFO i pops when rsp_i_valid && rsp_i_ready. rsp_i_data is the head entry, and rsp_i_valid = !empty.
  - Push and pop in the same cycle are both performed, including when full.
  - The credit limit guarantees a push never hits a full FIFO with no pop. A push into a full FIFO with no pop is an assertion failure.
  - Pointers wrap modulo FDEPTH.
- Ordering: per-requester results leave in accept order. There is no ordering between requesters.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. The unit's later mr_result values are ignored because the tags are cleared.
- The block never modifies data: rsp data equals mr_result bit-for-bit.

Test Plan:
- Single op: requester 0 issues a=32'd2285 in cycle 5, bench unit model returns Montgomery(a)=16'd1 → rsp0_valid in cycle 9, rsp0_data=1, requester 1 gets nothing.
- Contention: both valid continuously with rsp ready=1 → grants alternate 0,1,0,1,… and each requester sustains one op every 2 cycles.
- Backpressure: rsp0_ready=0 while requester 0 streams → exactly FDEPTH=4 accepts, then req0_ready=0. Requester 1 continues at full rate. Raising rsp0_ready drains 4 results in order.
- Simultaneous push/pop at full: FIFO0 holds 4 and credit0=4. In one cycle a pop occurs with no in-flight push → credit0=3 and the next accept is allowed the following cycle with no data loss.
- Reset mid-flight: assert rst for 1 cycle while 2 ops are in flight → no rsp_valid afterwards, credits=0, and a fresh op completes with the normal latency.
- Sweep MR_LAT=1,2,4 with random valid/ready and a scoreboard → data matches, order is preserved, and there are no drops or duplicates.

Source files
------------

// File: rtl/mont_reduce_arbiter.sv
// Round-robin front end that shares one fixed-latency Montgomery reduction unit
// between two requesters, returning results in per-requester issue order.
module mont_reduce_arbiter #(
  parameter int MR_LAT = 2,
  parameter int FDEPTH = 4,
  parameter int DWID   = 32,
  parameter int RWID   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DWID-1:0] req0_a,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DWID-1:0] req1_a,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [RWID-1:0] rsp0_data,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [RWID-1:0] rsp1_data,
  output logic            mr_valid,
  output logic [DWID-1:0] mr_a,
  input  logic [RWID-1:0] mr_result
);

  localparam int PW   = $clog2(FDEPTH);
  localparam int PTRW = PW + 1;
  localparam int CW   = $clog2(FDEPTH + 1);

  logic [1:0]      req_valid, rsp_ready, elig, grant, credit_ok, push, pop, not_empty;
  logic [RWID-1:0] head_data [2];
  logic            prio_q, prio_d;
  logic [DWID-1:0] mr_a_q, mr_a_d;
  // Bit 0 is the issue register; bit MR_LAT lines up with mr_result.
  logic [MR_LAT:0] tag_v_q, tag_v_d, tag_o_q, tag_o_d;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    elig  = req_valid & credit_ok;
    grant = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) grant[prio_q] = 1'b1;
      else               grant = elig;
    end
    prio_d = prio_q;
    if (|grant) prio_d = grant[0];
    mr_a_d = mr_a_q;
    if (grant[0])      mr_a_d = req0_a;
    else if (grant[1]) mr_a_d = req1_a;
    tag_v_d = {tag_v_q[MR_LAT-1:0], |grant};
    tag_o_d = {tag_o_q[MR_LAT-1:0], grant[1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= 1'b0;
      mr_a_q  <= '0;
      tag_v_q <= '0;
      tag_o_q <= '0;
    end else begin
      prio_q  <= prio_d;
      mr_a_q  <= mr_a_d;
      tag_v_q <= tag_v_d;
      tag_o_q <= tag_o_d;
    end
  end

  assign mr_valid = tag_v_q[0];
  assign mr_a     = mr_a_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [CW-1:0]   credit_q, credit_d;
    logic [PTRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [RWID-1:0] mem_q [FDEPTH];
    logic [RWID-1:0] mem_d [FDEPTH];
    logic            full;

    assign push[gi]      = tag_v_q[MR_LAT] & (tag_o_q[MR_LAT] == 1'(gi));
    assign not_empty[gi] = (wptr_q != rptr_q);
    assign full          = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign pop[gi]       = not_empty[gi] & rsp_ready[gi];
    assign credit_ok[gi] = (credit_q < CW'(FDEPTH));
    assign head_data[gi] = mem_q[rptr_q[PW-1:0]];

    always_comb begin
      mem_d    = mem_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      credit_d = credit_q;
      if (push[gi]) begin
        mem_d[wptr_q[PW-1:0]] = mr_result;
        wptr_d = wptr_q + PTRW'(1);
      end
      if (pop[gi]) rptr_d = rptr_q + PTRW'(1);
      if (grant[gi] && !pop[gi])      credit_d = credit_q + CW'(1);
      else if (!grant[gi] && pop[gi]) credit_d = credit_q - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        credit_q <= '0;
        wptr_q   <= '0;
        rptr_q   <= '0;
        for (int j = 0; j < FDEPTH; j++) mem_q[j] <= '0;
      end else begin
        credit_q <= credit_d;
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        mem_q    <= mem_d;
      end
    end

    // Credits bound in-flight plus stored results, so a lone push never meets a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push[gi] && full && !pop[gi]));
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = not_empty[0];
  assign rsp1_valid = not_empty[1];
  assign rsp0_data  = head_data[0];
  assign rsp1_data  = head_data[1];

endmodule

// File: tb/tb_mont_reduce_arbiter.sv
// Bench for mont_reduce_arbiter: three instances (MR_LAT = 2, 1, 4) run in lockstep
// against a queue/credit reference model plus directed corner-case sequences.
module tb_mont_reduce_arbiter;
  localparam int NI = 3;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0_valid [NI], req0_ready [NI], req1_valid [NI], req1_ready [NI];
  logic        rsp0_valid [NI], rsp0_ready [NI], rsp1_valid [NI], rsp1_ready [NI];
  logic        mr_valid [NI];
  logic [31:0] req0_a [NI], req1_a [NI], mr_a [NI];
  logic [15:0] rsp0_data [NI], rsp1_data [NI], mr_result [NI];

  int lat_of [NI] = '{2, 1, 4};

  // Kyber-style reduction: a * 2^-16 mod 3329 (169 is the inverse of 2^16).
  function automatic logic [15:0] mont(input logic [31:0] a);
    longint unsigned t;
    t = 64'(a);
    t = (t % 3329) * 169 % 3329;
    return t[15:0];
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    logic [15:0] pipe [LAT];

    mont_reduce_arbiter #(.MR_LAT(LAT), .FDEPTH(FD), .DWID(32), .RWID(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid[gi]), .req0_ready(req0_ready[gi]), .req0_a(req0_a[gi]),
      .req1_valid(req1_valid[gi]), .req1_ready(req1_ready[gi]), .req1_a(req1_a[gi]),
      .rsp0_valid(rsp0_valid[gi]), .rsp0_ready(rsp0_ready[gi]), .rsp0_data(rsp0_data[gi]),
      .rsp1_valid(rsp1_valid[gi]), .rsp1_ready(rsp1_ready[gi]), .rsp1_data(rsp1_data[gi]),
      .mr_valid(mr_valid[gi]), .mr_a(mr_a[gi]), .mr_result(mr_result[gi])
    );

    always @(posedge clk) begin
      pipe[0] <= mont(mr_a[gi]);
      for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign mr_result[gi] = pipe[LAT-1];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s inst%0d: got %0d expected %0d", nm, k, act, exp_v);
    end
  endtask

  // Reference model: credits = accepted minus popped, prio flips on any grant,
  // and each requester's expected results wait in a FIFO queue.
  int          cred [NI][2];
  bit          prio_m [NI];
  int          acc_cnt [NI][2];
  logic [15:0] exp_q [2*NI][$];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic        v [2], r [2], rv [2], rr [2], e [2], g [2];
      logic [31:0] a [2];
      logic [15:0] d [2];
      v[0] = req0_valid[k]; v[1] = req1_valid[k];
      r[0] = req0_ready[k]; r[1] = req1_ready[k];
      rv[0] = rsp0_valid[k]; rv[1] = rsp1_valid[k];
      rr[0] = rsp0_ready[k]; rr[1] = rsp1_ready[k];
      a[0] = req0_a[k]; a[1] = req1_a[k];
      d[0] = rsp0_data[k]; d[1] = rsp1_data[k];
      if (rst) begin
        chk("ready_in_reset", k, {62'd0, r[1], r[0]}, 64'd0);
        prio_m[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          cred[k][i] = 0;
          exp_q[2*k+i].delete();
        end
        continue;
      end
      for (int i = 0; i < 2; i++) e[i] = v[i] && (cred[k][i] < FD);
      g[0] = e[0] && (!e[1] || !prio_m[k]);
      g[1] = e[1] && (!e[0] || prio_m[k]);
      chk("req0_ready", k, 64'(r[0]), 64'(g[0]));
      chk("req1_ready", k, 64'(r[1]), 64'(g[1]));
      for (int i = 0; i < 2; i++) begin
        if (rv[i] === 1'b1) begin
          if (exp_q[2*k+i].size() == 0) begin
            chk(i == 0 ? "rsp0_unexpected" : "rsp1_unexpected", k, 64'd1, 64'd0);
          end else begin
            chk(i == 0 ? "rsp0_data" : "rsp1_data", k, 64'(d[i]), 64'(exp_q[2*k+i][0]));
            if (rr[i]) begin
              void'(exp_q[2*k+i].pop_front());
              cred[k][i]--;
            end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i] && r[i]) begin
          exp_q[2*k+i].push_back(mont(a[i]));
          cred[k][i]++;
          acc_cnt[k][i]++;
        end
      end
      if ((v[0] && r[0]) || (v[1] && r[1])) prio_m[k] = (v[0] && r[0]);
    end
  end

  task automatic drive(input logic v0, input logic v1, input logic rr0, input logic rr1);
    for (int k = 0; k < NI; k++) begin
      req0_valid[k] = v0; req1_valid[k] = v1;
      rsp0_ready[k] = rr0; rsp1_ready[k] = rr1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      req0_a[k] = $urandom;
      req1_a[k] = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain_check(input string nm);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (20) step();
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 2; i++) chk(nm, k, 64'(exp_q[2*k+i].size()), 64'd0);
  endtask

  task automatic single_op();
    int          first [NI];
    logic [15:0] dat [NI];
    bit          r1seen [NI];
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < NI; k++) begin
      req0_a[k] = 32'd2285;
      first[k] = -1; dat[k] = '0; r1seen[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("single_accept", k, 64'(req0_ready[k]), 64'd1);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (rsp0_valid[k] && first[k] < 0) begin
          first[k] = n;
          dat[k] = rsp0_data[k];
        end
        if (rsp1_valid[k]) r1seen[k] = 1'b1;
      end
      step();
    end
    for (int k = 0; k < NI; k++) begin
      chk("single_latency", k, 64'(first[k]), 64'(lat_of[k] + 2));
      chk("single_data", k, 64'(dat[k]), 64'd1);
      chk("single_rsp1_quiet", k, 64'(r1seen[k]), 64'd0);
    end
  endtask

  typedef struct packed {
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int b0 [NI], b1 [NI];
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NI; k++) begin
      req0_a[k] = '0;
      req1_a[k] = '0;
    end
    step();
    step();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_mr_valid", k, 64'(mr_valid[k]), 64'd0);
      chk("rst_mr_a", k, 64'(mr_a[k]), 64'd0);
      chk("rst_rsp_valid", k, {62'd0, rsp1_valid[k], rsp0_valid[k]}, 64'd0);
      chk("rst_rsp0_data", k, 64'(rsp0_data[k]), 64'd0);
      chk("rst_rsp1_data", k, 64'(rsp1_data[k]), 64'd0);
    end
    rst = 1'b0;
    step();

    single_op();
    drain_check("single_drain");

    // Arbitration table from a fresh reset.
    do_reset();
    for (int t = 0; t < 10; t++) begin
      drive(tbl[t].v0, tbl[t].v1, 1'b1, 1'b1);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("tbl_ready0", k, 64'(req0_ready[k]), 64'(tbl[t].r0));
        chk("tbl_ready1", k, 64'(req1_ready[k]), 64'(tbl[t].r1));
      end
      step();
    end
    drain_check("tbl_drain");

    // Requester 0 backpressured: its credits cap it at FD accepts.
    do_reset();
    for (int k = 0; k < NI; k++) begin
      b0[k] = acc_cnt[k][0];
      b1[k] = acc_cnt[k][1];
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (30) step();
    for (int k = 0; k < NI; k++) begin
      chk("bp_req0_accepts", k, 64'(acc_cnt[k][0] - b0[k]), 64'(FD));
      chk("bp_req1_progress", k, 64'(acc_cnt[k][1] - b1[k] >= 8), 64'd1);
    end

    // Full FIFO, one pop: ready stays low that cycle, returns the next.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (10) step();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("full_pop_ready", k, 64'(req0_ready[k]), 64'd0);
      chk("full_pop_valid", k, 64'(rsp0_valid[k]), 64'd1);
    end
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("after_pop_ready", k, 64'(req0_ready[k]), 64'd1);
    step();
    drain_check("bp_drain");
    for (int k = 0; k < NI; k++) chk("bp_total_accepts", k, 64'(acc_cnt[k][0] - b0[k]), 64'(FD + 1));

    // Reset with two ops in flight: nothing may come back.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++)
        chk("flush_quiet", k, {62'd0, rsp1_valid[k], rsp0_valid[k]}, 64'd0);
      step();
    end
    single_op();
    drain_check("flush_drain");

    // Random traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    drain_check("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule
